// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst initiator streaming words between valid/ready ports and a single-port word memory
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready           burst command handshake; cmd_ready high only when idle
//   cmd_write, cmd_addr, cmd_len  direction (1 = write), start word address, word count (0..2^ADDR_W)
//   wr_valid/wr_ready/wr_data     write-word stream into the memory
//   rd_valid/rd_ready/rd_data     registered read-word stream out of the memory
//   busy, done                    busy outside IDLE; done is a one-cycle end-of-burst pulse
//   mem_we/mem_addr/mem_wdata     memory master port (1-cycle write)
//   mem_rdata                     memory read data, combinational from mem_addr
module mem_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic                dir_q, dir_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    // Status outputs are registered copies of the next-state decode, so they
    // line up with state_q without any combinational path from the inputs.
    logic                cmd_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                wr_ready_q;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    dir_d       = cmd_write;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                // The output register can take a new word whenever it is empty
                // or its current word is being consumed this cycle.
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d   = mem_rdata;
                    rd_valid_d  = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            wr_ready_q  <= (state_d == S_WRITE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

    // rst gates the strobe directly so a reset cycle mid-burst never commits a word.
    assign mem_we    = wr_ready_q & dir_q & wr_valid & ~rst;
    assign mem_addr  = cur_addr_q;
    assign mem_wdata = wr_data;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - directed self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wbuf [$];
    logic [31:0] got  [$];

    mem_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic w, input logic [7:0] a, input logic [8:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        #1;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Write burst from wbuf; gaps=1 drops wr_valid on every other cycle.
    task automatic wr_burst(input logic [7:0] a, input logic [8:0] l, input bit gaps, input int exp_cyc);
        int         sent = 0;
        int         cyc  = 0;
        bit         bad  = 0;
        logic [7:0] ea   = a;
        do_cmd(1'b1, a, l);
        while (sent < int'(l) && cyc < 2000) begin
            wr_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            wr_data  = wbuf[sent];
            #1;
            if (mem_we !== wr_valid || wr_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) bad = 1;
            if (wr_valid && mem_addr !== ea) bad = 1;
            if (wr_valid) begin
                sent++;
                ea++;
            end
            cyc++;
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("wr_sequence", {31'd0, bad}, 32'd0);
        chk("wr_cycles", cyc, exp_cyc);
        chk("wr_done_pulse", {31'd0, done}, 32'd1);
        chk("wr_done_busy", {31'd0, busy}, 32'd1);
        chk("wr_done_no_cmd", {31'd0, cmd_ready}, 32'd0);
        chk("wr_done_no_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("wr_done_clear", {31'd0, done}, 32'd0);
        chk("wr_idle_cmd", {31'd0, cmd_ready}, 32'd1);
        chk("wr_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    // Read burst into got; toggle=1 drives rd_ready 1,0,0,1,0,0,...
    task automatic rd_burst(input logic [7:0] a, input logic [8:0] l, input bit toggle, input int exp_done_cyc);
        int          cyc = 0;
        int          done_cyc = -1;
        bit          held = 0;
        bit          bad = 0;
        logic [31:0] hd = '0;
        got.delete();
        do_cmd(1'b0, a, l);
        while (cyc < 3000) begin
            rd_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (mem_we !== 1'b0) bad = 1;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (rd_valid === 1'b1) begin
                if (held && rd_data !== hd) bad = 1;
                if (rd_ready) begin
                    got.push_back(rd_data);
                    held = 0;
                end else begin
                    held = 1;
                    hd   = rd_data;
                end
            end else if (held) begin
                bad = 1;
            end
            cyc++;
            tick();
        end
        rd_ready = 1'b0;
        chk("rd_stable_no_we", {31'd0, bad}, 32'd0);
        chk("rd_count", 32'(got.size()), 32'(l));
        if (exp_done_cyc >= 0) chk("rd_done_cycle", done_cyc, exp_done_cyc);
        chk("rd_done_no_cmd", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("rd_done_clear", {31'd0, done}, 32'd0);
        chk("rd_idle_cmd", {31'd0, cmd_ready}, 32'd1);
        chk("rd_idle_valid", {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit bad;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        tick();
        tick();
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);

        // Write 4 then read 4 at 0x10, full throughput.
        wbuf = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        wr_burst(8'h10, 9'd4, 1'b0, 4);
        rd_burst(8'h10, 9'd4, 1'b0, 5);
        chk("wr_rd_0", got[0], 32'hA0);
        chk("wr_rd_1", got[1], 32'hA1);
        chk("wr_rd_2", got[2], 32'hA2);
        chk("wr_rd_3", got[3], 32'hA3);

        // Address wrap at the top of the space.
        wbuf = '{32'd1, 32'd2, 32'd3};
        wr_burst(8'hFE, 9'd3, 1'b0, 3);
        chk("wrap_mem_fe", mem[8'hFE], 32'd1);
        chk("wrap_mem_ff", mem[8'hFF], 32'd2);
        chk("wrap_mem_00", mem[8'h00], 32'd3);
        rd_burst(8'hFE, 9'd3, 1'b0, 4);
        chk("wrap_rd_0", got[0], 32'd1);
        chk("wrap_rd_1", got[1], 32'd2);
        chk("wrap_rd_2", got[2], 32'd3);

        // Write with wr_valid gaps, then read back under rd_ready backpressure.
        wbuf = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        wr_burst(8'h80, 9'd4, 1'b1, 7);
        rd_burst(8'h80, 9'd4, 1'b1, -1);
        chk("bp_rd_0", got[0], 32'hB0);
        chk("bp_rd_1", got[1], 32'hB1);
        chk("bp_rd_2", got[2], 32'hB2);
        chk("bp_rd_3", got[3], 32'hB3);

        // Zero-length read and write: no memory activity, done right after acceptance.
        for (int w = 0; w < 2; w++) begin
            do_cmd(w[0], 8'h33, 9'd0);
            chk("zero_done", {31'd0, done}, 32'd1);
            chk("zero_we", {31'd0, mem_we}, 32'd0);
            chk("zero_rd_valid", {31'd0, rd_valid}, 32'd0);
            tick();
            chk("zero_done_clear", {31'd0, done}, 32'd0);
            chk("zero_idle", {31'd0, cmd_ready}, 32'd1);
        end

        // Full address space: data = address.
        wbuf.delete();
        for (int i = 0; i < 256; i++) wbuf.push_back(32'(i));
        wr_burst(8'h00, 9'd256, 1'b0, 256);
        rd_burst(8'h00, 9'd256, 1'b0, 257);
        bad = 0;
        for (int i = 0; i < 256 && i < got.size(); i++) begin
            if (got[i] !== 32'(i)) bad = 1;
        end
        chk("full_data", {31'd0, bad}, 32'd0);

        // Reset during the 3rd write cycle: that word is dropped, no done pulse.
        wbuf = '{32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
        wr_burst(8'h40, 9'd4, 1'b0, 4);
        do_cmd(1'b1, 8'h40, 9'd4);
        wr_valid = 1'b1;
        wr_data  = 32'h11;
        tick();
        wr_data  = 32'h12;
        tick();
        wr_data  = 32'h13;
        rst      = 1'b1;
        #1;
        chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
        tick();
        rst      = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_mid_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_mid_mem40", mem[8'h40], 32'h11);
        chk("rst_mid_mem41", mem[8'h41], 32'h12);
        chk("rst_mid_mem42", mem[8'h42], 32'hDEAD);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0) bad = 1;
            tick();
        end
        chk("rst_mid_no_done", {31'd0, bad}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst initiator for the PMU's single-port 32-bit word memory (1-cycle write, combinational read). Accepts a burst command (direction, start address, length), then streams words between valid/ready data ports and the memory port, one word per cycle at full throughput. It is the master side of the memory port, replacing ad-hoc address/write-enable sequencing in PMU logic.

## Interface
- ADDR_W, 8, memory address width; the address space is 2^ADDR_W words.
- DATA_W, 32, word width.
- LEN_W, ADDR_W+1, width of the burst length; the maximum legal length is 2^ADDR_W.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller accepts a command (high only in IDLE).
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  LEN_W  number of words, 0..2^ADDR_W.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write word accepted (high only in WRITE).
- wr_data  in  DATA_W  write word.
- rd_valid  out  1  read word available (registered).
- rd_ready  in  1  consumer accepts the read word.
- rd_data  out  DATA_W  read word (registered).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a burst.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Registers:
  - cur_addr (ADDR_W).
  - remaining (LEN_W).
  - dir.
  - rd_valid and rd_data.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_addr→cur_addr, cmd_len→remaining, and cmd_write→dir.
  - Next state: len==0 → DONE with no memory access; otherwise WRITE or READ.
- WRITE:
  - wr_ready=1.
  - mem_we = wr_valid & !rst; mem_addr=cur_addr; mem_wdata=wr_data (combinational pass-through).
  - Each wr_valid cycle: cur_addr+1 (wraps 2^ADDR_W-1 → 0), remaining-1.
  - Handshake with remaining==1 → DONE.
  - wr_valid low stalls the burst with no write.
- READ:
  - mem_addr=cur_addr.
  - When !rd_valid | rd_ready: load rd_data←mem_rdata, set rd_valid=1, then advance cur_addr and remaining.
  - The load with remaining==1 → DRAIN.
- DRAIN:
  - Hold the last word.
  - On rd_valid & rd_ready: clear rd_valid → DONE.
  - In READ, a consumed word with no new load clears rd_valid.
- DONE: done=1, busy=1, cmd_ready=0 → IDLE next cycle.
- mem_we=0 in every state except WRITE.
- mem_addr=cur_addr in all states.
- mem_wdata=wr_data at all times.
- Reset values:
  - State IDLE.
  - cur_addr=0, remaining=0.
  - rd_valid=0, rd_data=0.
  - done=0, busy=0, cmd_ready=1 (after reset), wr_ready=0, mem_we=0.
- Reset mid-burst aborts immediately:
  - mem_we is forced 0 in the rst cycle, so no write commits.
  - No done pulse.
  - A pending read word is discarded.
- Commands offered while busy are ignored (cmd_ready=0). A length above 2^ADDR_W is illegal and its behaviour is undefined.

## Timing
- Edge E0 = the command handshake.
- Write burst of N words with wr_valid held high:
  - Writes commit at edges E1..EN.
  - done is high in the cycle after EN; cmd_ready returns one cycle later.
- Read burst of N words with rd_ready held high:
  - rd_valid is first high after E1 (word at cmd_addr).
  - One word per cycle through edge EN.
  - The last word is consumed at E(N+1) (DRAIN).
  - done is high in the following cycle.
- rd_valid and rd_data hold stable while rd_ready is low; there is no data loss and no duplication.
- Zero-length burst: DONE in the cycle after E0; done high for exactly 1 cycle.
- Back-to-back commands: minimum spacing is burst + 2 cycles (DONE, then IDLE).

## Test plan
- Write then read: write 4 words 0xA0..0xA3 at addr 0x10, then read 4 from 0x10 → rd_data sequence A0,A1,A2,A3; done pulses once per burst; 6-cycle write-to-idle.
- Wrap: write len 3 at 0xFE (data 1,2,3) → memory 0xFE=1, 0xFF=2, 0x00=3; a read-back at 0xFE returns 1,2,3.
- Backpressure: read len 4 with rd_ready toggling 1,0,0,1,... → every word delivered exactly once, in order, with rd_data stable while stalled; wr_valid gaps during a write burst produce no spurious mem_we.
- Full space: len 256 write of data=addr, then a len 256 read → data equals index 0..255; no early done.
- Zero length: cmd_len=0 → no mem_we, no rd_valid; done high 1 cycle after acceptance.
- Reset mid-burst: assert rst during the 3rd write cycle with wr_valid high → that word is not written; state IDLE, busy=0, cmd_ready=1 next cycle; no done pulse.
